// File: rtl/logic_selftest.sv
`default_nettype none
// ============================================================================
// Module   : logic_selftest
// Purpose  : Exhaustive operand-sweep self-test for bitwise AND/OR/XOR units;
//            counts mismatches (saturating) and captures the first failure.
// Revision : 1.0  initial release
// ============================================================================
module logic_selftest #(
    parameter int WIDTH   = 64,
    parameter int OP_BITS = 8,
    parameter int SETTLE  = 1,
    parameter int ERR_W   = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op_sel,
    input  logic               rep,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH-1:0]   dut_s,
    output logic               busy,
    output logic               done,
    output logic [ERR_W-1:0]   err_count,
    output logic               first_err_valid,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b,
    output logic [WIDTH-1:0]   first_err_s
);

    localparam int c_REPS  = WIDTH / OP_BITS;
    localparam int c_SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [OP_BITS-1:0]   r_i;
    logic [OP_BITS-1:0]   r_j;
    logic [c_SET_W-1:0]   r_settle;
    logic [1:0]           r_op_sel;
    logic                 r_rep;

    logic [WIDTH-1:0]     w_expect;
    logic                 w_mismatch;
    logic                 w_last;
    logic [OP_BITS-1:0]   w_next_i;
    logic [OP_BITS-1:0]   w_next_j;

    function automatic logic [WIDTH-1:0] f_map(input logic [OP_BITS-1:0] v,
                                               input logic rp);
        return rp ? {c_REPS{v}} : WIDTH'(v);
    endfunction

    // Expected result is formed from the registered operands, so it is
    // aligned with the vector the unit under test is currently seeing.
    always_comb begin
        w_expect = op_a & op_b;
        unique case (r_op_sel)
            2'b01:   w_expect = op_a | op_b;
            2'b10:   w_expect = op_a ^ op_b;
            default: w_expect = op_a & op_b;
        endcase
    end

    assign w_mismatch = (dut_s != w_expect);
    assign w_last     = &{r_i, r_j};
    assign w_next_j   = r_j + 1'b1;
    assign w_next_i   = (&r_j) ? (r_i + 1'b1) : r_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_i             <= '0;
            r_j             <= '0;
            r_settle        <= '0;
            r_op_sel        <= '0;
            r_rep           <= 1'b0;
            op_a            <= '0;
            op_b            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_s     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op_sel        <= op_sel;
                        r_rep           <= rep;
                        r_i             <= '0;
                        r_j             <= '0;
                        r_settle        <= '0;
                        op_a            <= '0;
                        op_b            <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_a     <= '0;
                        first_err_b     <= '0;
                        first_err_s     <= '0;
                        r_state         <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_settle == c_SET_W'(SETTLE - 1)) begin
                        r_settle <= '0;
                        r_state  <= S_CHECK;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (!(&err_count)) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_a     <= op_a;
                            first_err_b     <= op_b;
                            first_err_s     <= dut_s;
                        end
                    end
                    // Operands stay on the last vector once the sweep ends.
                    if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_i     <= w_next_i;
                        r_j     <= w_next_j;
                        op_a    <= f_map(w_next_i, r_rep);
                        op_b    <= f_map(w_next_j, r_rep);
                        r_state <= S_DRIVE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_selftest.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_selftest
// Purpose  : Directed self-checking bench for logic_selftest on a reduced
//            16-bit / 4-bit-sweep configuration with a faultable unit model.
// Revision : 1.0  initial release
// ============================================================================
module tb_logic_selftest;

    localparam int WIDTH   = 16;
    localparam int OP_BITS = 4;
    localparam int SETTLE  = 2;
    localparam int ERR_W   = 7;
    localparam int c_SWEEP = 256 * (SETTLE + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [1:0]         op_sel = 2'b00;
    logic               rep = 1'b0;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   dut_s;
    logic               busy;
    logic               done;
    logic [ERR_W-1:0]   err_count;
    logic               first_err_valid;
    logic [WIDTH-1:0]   first_err_a;
    logic [WIDTH-1:0]   first_err_b;
    logic [WIDTH-1:0]   first_err_s;

    int n_checks = 0;
    int n_errors = 0;
    int mode     = 0;
    int cyc;

    logic_selftest #(
        .WIDTH(WIDTH), .OP_BITS(OP_BITS), .SETTLE(SETTLE), .ERR_W(ERR_W)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .rep(rep),
        .op_a(op_a), .op_b(op_b), .dut_s(dut_s), .busy(busy), .done(done),
        .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_a(first_err_a), .first_err_b(first_err_b),
        .first_err_s(first_err_s)
    );

    always #5 clk = ~clk;

    // Unit under test model: 0 AND, 1 AND bit0 stuck-1, 2 AND MSB stuck-0,
    // 3 XOR, 4 AND bit0 stuck-0.
    always_comb begin
        dut_s = op_a & op_b;
        case (mode)
            1:       dut_s = (op_a & op_b) | 16'h0001;
            2:       dut_s = (op_a & op_b) & 16'h7FFF;
            3:       dut_s = op_a ^ op_b;
            4:       dut_s = (op_a & op_b) & 16'hFFFE;
            default: dut_s = op_a & op_b;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic sweep(input int m, input logic [1:0] sel, input logic rp,
                         input bit poke, output int cycles);
        mode   = m;
        op_sel = sel;
        rep    = rp;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_t0", 64'(busy), 64'd1);
        check("done_t0", 64'(done), 64'd0);
        check("opa_t0",  64'(op_a), 64'd0);
        check("opb_t0",  64'(op_b), 64'd0);
        cycles = 0;
        while (!done && cycles < 4 * c_SWEEP) begin
            @(posedge clk); #1;
            cycles++;
            if (poke && cycles == 300) begin
                start  = 1'b1;
                op_sel = 2'b01;
                rep    = ~rp;
            end else if (poke && cycles == 301) begin
                start = 1'b0;
            end
        end
        check("sweep_timeout", 64'(done), 64'd1);
        check("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err",  64'(err_count), 64'd0);
        check("rst_fev",  64'(first_err_valid), 64'd0);
        check("rst_opa",  64'(op_a), 64'd0);
        check("rst_fes",  64'(first_err_s), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean AND sweep.
        sweep(0, 2'b00, 1'b0, 1'b0, cyc);
        check("and_len", 64'(cyc), 64'(c_SWEEP));
        check("and_err", 64'(err_count), 64'd0);
        check("and_fev", 64'(first_err_valid), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("frozen_done", 64'(done), 64'd1);

        // Bit0 stuck-1: 192 mismatches saturate at 127.
        sweep(1, 2'b00, 1'b0, 1'b0, cyc);
        check("sa1_err", 64'(err_count), 64'd127);
        check("sa1_fev", 64'(first_err_valid), 64'd1);
        check("sa1_fea", 64'(first_err_a), 64'h0000);
        check("sa1_feb", 64'(first_err_b), 64'h0000);
        check("sa1_fes", 64'(first_err_s), 64'h0001);

        // MSB stuck-0 with replicated operands: i[3]&j[3] -> 64.
        sweep(2, 2'b00, 1'b1, 1'b0, cyc);
        check("msb_len", 64'(cyc), 64'(c_SWEEP));
        check("msb_err", 64'(err_count), 64'd64);
        check("msb_fea", 64'(first_err_a), 64'h8888);
        check("msb_feb", 64'(first_err_b), 64'h8888);
        check("msb_fes", 64'(first_err_s), 64'h0888);

        // AND unit against OR expectation: 240 mismatches saturate.
        sweep(0, 2'b01, 1'b0, 1'b0, cyc);
        check("or_err", 64'(err_count), 64'd127);
        check("or_fea", 64'(first_err_a), 64'h0000);
        check("or_feb", 64'(first_err_b), 64'h0001);
        check("or_fes", 64'(first_err_s), 64'h0000);

        // Bit0 stuck-0: a[0]&b[0] -> 64, first at (1,1).
        sweep(4, 2'b00, 1'b0, 1'b0, cyc);
        check("sa0_err", 64'(err_count), 64'd64);
        check("sa0_fea", 64'(first_err_a), 64'h0001);
        check("sa0_feb", 64'(first_err_b), 64'h0001);
        check("sa0_fes", 64'(first_err_s), 64'h0000);

        // Correct XOR unit, replicated operands.
        sweep(3, 2'b10, 1'b1, 1'b0, cyc);
        check("xor_err", 64'(err_count), 64'd0);
        check("xor_fev", 64'(first_err_valid), 64'd0);

        // op_sel=11 behaves as AND; mid-sweep start/op_sel/rep changes ignored.
        sweep(0, 2'b11, 1'b0, 1'b1, cyc);
        check("poke_len", 64'(cyc), 64'(c_SWEEP));
        check("poke_err", 64'(err_count), 64'd0);
        check("poke_opa", 64'(op_a), 64'h000F);

        // Start accepted from DONE clears results immediately.
        mode   = 4;
        op_sel = 2'b00;
        rep    = 1'b0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rs_done", 64'(done), 64'd0);
        check("rs_busy", 64'(busy), 64'd1);
        check("rs_opb",  64'(op_b), 64'd0);

        // Reset 500 cycles into a faulty sweep.
        repeat (499) @(posedge clk);
        #1;
        check("pre_rst_err", 64'(err_count != 0), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_err",  64'(err_count), 64'd0);
        check("mid_rst_fev",  64'(first_err_valid), 64'd0);
        check("mid_rst_opa",  64'(op_a), 64'd0);
        check("mid_rst_opb",  64'(op_b), 64'd0);

        sweep(4, 2'b00, 1'b0, 1'b0, cyc);
        check("post_rst_len", 64'(cyc), 64'(c_SWEEP));
        check("post_rst_err", 64'(err_count), 64'd64);
        check("post_rst_fea", 64'(first_err_a), 64'h0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
